// File: rtl/idu_is_miq_queue_if.sv
// ---------------------------------------------------------------------------
// idu_is_miq_queue_if
//   Bundles the issue-queue traffic: rename-side create bus, wakeup buses,
//   EXU-side issue handshake, global flush and occupancy status.
//   master : the rename / EXU / RTU side that drives create, wakeup, flush
//            and issue_rdy, and observes the queue outputs.
//   slave  : the issue queue itself.
// ---------------------------------------------------------------------------
interface idu_is_miq_queue_if #(
  parameter int IID_W  = 5,
  parameter int PREG_W = 6,
  parameter int OP_W   = 17,
  parameter int NUM_WK = 10,
  parameter int CNT_W  = 4
);
  logic                     rtu_global_flush;
  logic                     create_vld;
  logic                     create_rdy;
  logic [IID_W-1:0]         create_iid;
  logic [OP_W-1:0]          create_op;
  logic                     create_psrc1_vld;
  logic                     create_psrc1_ready;
  logic [PREG_W-1:0]        create_psrc1;
  logic                     create_psrc2_vld;
  logic                     create_psrc2_ready;
  logic [PREG_W-1:0]        create_psrc2;
  logic                     create_pdst_vld;
  logic [PREG_W-1:0]        create_pdst;
  logic [NUM_WK-1:0]        wk_vld;
  logic [NUM_WK*PREG_W-1:0] wk_preg;
  logic                     issue_vld;
  logic                     issue_rdy;
  logic [IID_W-1:0]         issue_iid;
  logic [OP_W-1:0]          issue_op;
  logic                     issue_psrc1_vld;
  logic [PREG_W-1:0]        issue_psrc1;
  logic                     issue_psrc2_vld;
  logic [PREG_W-1:0]        issue_psrc2;
  logic                     issue_pdst_vld;
  logic [PREG_W-1:0]        issue_pdst;
  logic [CNT_W-1:0]         entry_cnt;
  logic                     empty;

  modport master (
    output rtu_global_flush, create_vld, create_iid, create_op,
           create_psrc1_vld, create_psrc1_ready, create_psrc1,
           create_psrc2_vld, create_psrc2_ready, create_psrc2,
           create_pdst_vld, create_pdst, wk_vld, wk_preg, issue_rdy,
    input  create_rdy, issue_vld, issue_iid, issue_op,
           issue_psrc1_vld, issue_psrc1, issue_psrc2_vld, issue_psrc2,
           issue_pdst_vld, issue_pdst, entry_cnt, empty
  );

  modport slave (
    input  rtu_global_flush, create_vld, create_iid, create_op,
           create_psrc1_vld, create_psrc1_ready, create_psrc1,
           create_psrc2_vld, create_psrc2_ready, create_psrc2,
           create_pdst_vld, create_pdst, wk_vld, wk_preg, issue_rdy,
    output create_rdy, issue_vld, issue_iid, issue_op,
           issue_psrc1_vld, issue_psrc1, issue_psrc2_vld, issue_psrc2,
           issue_pdst_vld, issue_pdst, entry_cnt, empty
  );
endinterface

// File: rtl/idu_is_miq_queue.sv
// ---------------------------------------------------------------------------
// idu_is_miq_queue
//   Multi-entry issue queue of the IDU issue stage. Holds up to DEPTH renamed
//   instructions, tracks source readiness through NUM_WK wakeup buses, and
//   issues the oldest ready entry to EXU over a valid/ready handshake.
//   Age order is kept in a DEPTH x DEPTH matrix (age_q[i][j]=1: i older).
// Ports
//   clk      : clock
//   rst_clk  : asynchronous active-low reset
//   miq_if   : slave modport carrying create bus, wakeup buses, flush,
//              issue handshake/fields, entry_cnt and empty
// ---------------------------------------------------------------------------
module idu_is_miq_queue #(
  parameter int DEPTH  = 8,
  parameter int IID_W  = 5,
  parameter int PREG_W = 6,
  parameter int OP_W   = 17,
  parameter int NUM_WK = 10,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_clk,
  idu_is_miq_queue_if.slave miq_if
);

  // Entry storage
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  s1v_q, s1v_d, s1r_q, s1r_d;
  logic [DEPTH-1:0]  s2v_q, s2v_d, s2r_q, s2r_d;
  logic [DEPTH-1:0]  pdv_q, pdv_d;
  logic [IID_W-1:0]  iid_q [DEPTH];
  logic [IID_W-1:0]  iid_d [DEPTH];
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [OP_W-1:0]   op_d  [DEPTH];
  logic [PREG_W-1:0] s1_q  [DEPTH];
  logic [PREG_W-1:0] s1_d  [DEPTH];
  logic [PREG_W-1:0] s2_q  [DEPTH];
  logic [PREG_W-1:0] s2_d  [DEPTH];
  logic [PREG_W-1:0] pd_q  [DEPTH];
  logic [PREG_W-1:0] pd_d  [DEPTH];
  logic [DEPTH-1:0]  age_q [DEPTH];
  logic [DEPTH-1:0]  age_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Control
  logic [DEPTH-1:0]  rdy_s;
  logic [DEPTH-1:0]  sel_s;
  logic [DEPTH-1:0]  alloc_s;
  logic              free_seen_s;
  logic              any_rdy_s;
  logic              issue_vld_s;
  logic              issue_fire_s;
  logic              create_rdy_s;
  logic              create_fire_s;
  logic              cr_s1_rdy_s;
  logic              cr_s2_rdy_s;

  // Issue field mux
  logic [IID_W-1:0]  iss_iid_s;
  logic [OP_W-1:0]   iss_op_s;
  logic              iss_s1v_s, iss_s2v_s, iss_pdv_s;
  logic [PREG_W-1:0] iss_s1_s, iss_s2_s, iss_pd_s;

  // Any wakeup bus carrying this preg this cycle
  function automatic logic wk_hit(input logic [PREG_W-1:0]        preg,
                                  input logic [NUM_WK-1:0]        vld,
                                  input logic [NUM_WK*PREG_W-1:0] bus);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WK; k++) begin
      hit = hit | (vld[k] & (bus[k*PREG_W +: PREG_W] == preg));
    end
    return hit;
  endfunction

  // Create readiness includes a same-cycle wakeup of the incoming source
  assign cr_s1_rdy_s = miq_if.create_psrc1_ready | ~miq_if.create_psrc1_vld |
                       wk_hit(miq_if.create_psrc1, miq_if.wk_vld, miq_if.wk_preg);
  assign cr_s2_rdy_s = miq_if.create_psrc2_ready | ~miq_if.create_psrc2_vld |
                       wk_hit(miq_if.create_psrc2, miq_if.wk_vld, miq_if.wk_preg);

  assign any_rdy_s     = |rdy_s;
  assign issue_vld_s   = any_rdy_s & ~miq_if.rtu_global_flush;
  assign issue_fire_s  = issue_vld_s & miq_if.issue_rdy;
  assign create_rdy_s  = (cnt_q != CNT_W'(DEPTH));
  assign create_fire_s = miq_if.create_vld & create_rdy_s & ~miq_if.rtu_global_flush;

  // Ready and oldest-ready select, from registered state only
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_s[i] = vld_q[i] & s1r_q[i] & s2r_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel_s[i] = rdy_s[i];
      for (int j = 0; j < DEPTH; j++) begin
        // i survives only if it is older than every other ready entry
        sel_s[i] = sel_s[i] & (age_q[i][j] | ~rdy_s[j] | (i == j));
      end
    end
  end

  // Lowest-index free slot; slots freed this cycle still look busy
  always_comb begin
    free_seen_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_s[i]  = ~vld_q[i] & ~free_seen_s;
      free_seen_s = free_seen_s | ~vld_q[i];
    end
  end

  // AND-OR mux of the one-hot selected entry; all-zero when none selected
  always_comb begin
    iss_iid_s = {IID_W{1'b0}};
    iss_op_s  = {OP_W{1'b0}};
    iss_s1v_s = 1'b0;
    iss_s2v_s = 1'b0;
    iss_pdv_s = 1'b0;
    iss_s1_s  = {PREG_W{1'b0}};
    iss_s2_s  = {PREG_W{1'b0}};
    iss_pd_s  = {PREG_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      iss_iid_s = iss_iid_s | (iid_q[i] & {IID_W{sel_s[i]}});
      iss_op_s  = iss_op_s  | (op_q[i]  & {OP_W{sel_s[i]}});
      iss_s1v_s = iss_s1v_s | (s1v_q[i] & sel_s[i]);
      iss_s2v_s = iss_s2v_s | (s2v_q[i] & sel_s[i]);
      iss_pdv_s = iss_pdv_s | (pdv_q[i] & sel_s[i]);
      iss_s1_s  = iss_s1_s  | (s1_q[i]  & {PREG_W{sel_s[i]}});
      iss_s2_s  = iss_s2_s  | (s2_q[i]  & {PREG_W{sel_s[i]}});
      iss_pd_s  = iss_pd_s  | (pd_q[i]  & {PREG_W{sel_s[i]}});
    end
  end

  // Per-entry next state: flush/issue clear, create load, resident wakeup
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i];
      iid_d[i] = iid_q[i];
      op_d[i]  = op_q[i];
      s1v_d[i] = s1v_q[i];
      s1r_d[i] = s1r_q[i];
      s1_d[i]  = s1_q[i];
      s2v_d[i] = s2v_q[i];
      s2r_d[i] = s2r_q[i];
      s2_d[i]  = s2_q[i];
      pdv_d[i] = pdv_q[i];
      pd_d[i]  = pd_q[i];
      if (miq_if.rtu_global_flush | (issue_fire_s & sel_s[i])) begin
        vld_d[i] = 1'b0;
        iid_d[i] = {IID_W{1'b0}};
        op_d[i]  = {OP_W{1'b0}};
        s1v_d[i] = 1'b0;
        s1r_d[i] = 1'b0;
        s1_d[i]  = {PREG_W{1'b0}};
        s2v_d[i] = 1'b0;
        s2r_d[i] = 1'b0;
        s2_d[i]  = {PREG_W{1'b0}};
        pdv_d[i] = 1'b0;
        pd_d[i]  = {PREG_W{1'b0}};
      end else if (create_fire_s & alloc_s[i]) begin
        vld_d[i] = 1'b1;
        iid_d[i] = miq_if.create_iid;
        op_d[i]  = miq_if.create_op;
        s1v_d[i] = miq_if.create_psrc1_vld;
        s1r_d[i] = cr_s1_rdy_s;
        s1_d[i]  = miq_if.create_psrc1;
        s2v_d[i] = miq_if.create_psrc2_vld;
        s2r_d[i] = cr_s2_rdy_s;
        s2_d[i]  = miq_if.create_psrc2;
        pdv_d[i] = miq_if.create_pdst_vld;
        pd_d[i]  = miq_if.create_pdst & {PREG_W{miq_if.create_pdst_vld}};
      end else begin
        // Readiness is sticky; free slots never pick up stray wakeups
        s1r_d[i] = s1r_q[i] | (vld_q[i] & wk_hit(s1_q[i], miq_if.wk_vld, miq_if.wk_preg));
        s2r_d[i] = s2r_q[i] | (vld_q[i] & wk_hit(s2_q[i], miq_if.wk_vld, miq_if.wk_preg));
      end
    end
  end

  // Age matrix update: new entry is youngest, issued entry drops out
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (miq_if.rtu_global_flush | (issue_fire_s & (sel_s[i] | sel_s[j]))) begin
          age_d[i][j] = 1'b0;
        end else if (create_fire_s & alloc_s[i]) begin
          age_d[i][j] = 1'b0;
        end else if (create_fire_s & alloc_s[j]) begin
          age_d[i][j] = vld_q[i];
        end else begin
          age_d[i][j] = age_q[i][j];
        end
      end
    end
  end

  // Occupancy counter
  always_comb begin
    if (miq_if.rtu_global_flush) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(create_fire_s) - CNT_W'(issue_fire_s);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      vld_q <= {DEPTH{1'b0}};
      s1v_q <= {DEPTH{1'b0}};
      s1r_q <= {DEPTH{1'b0}};
      s2v_q <= {DEPTH{1'b0}};
      s2r_q <= {DEPTH{1'b0}};
      pdv_q <= {DEPTH{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        iid_q[i] <= {IID_W{1'b0}};
        op_q[i]  <= {OP_W{1'b0}};
        s1_q[i]  <= {PREG_W{1'b0}};
        s2_q[i]  <= {PREG_W{1'b0}};
        pd_q[i]  <= {PREG_W{1'b0}};
        age_q[i] <= {DEPTH{1'b0}};
      end
    end else begin
      vld_q <= vld_d;
      s1v_q <= s1v_d;
      s1r_q <= s1r_d;
      s2v_q <= s2v_d;
      s2r_q <= s2r_d;
      pdv_q <= pdv_d;
      cnt_q <= cnt_d;
      iid_q <= iid_d;
      op_q  <= op_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      pd_q  <= pd_d;
      age_q <= age_d;
    end
  end

  assign miq_if.create_rdy      = create_rdy_s;
  assign miq_if.issue_vld       = issue_vld_s;
  assign miq_if.issue_iid       = iss_iid_s;
  assign miq_if.issue_op        = iss_op_s;
  assign miq_if.issue_psrc1_vld = iss_s1v_s;
  assign miq_if.issue_psrc1     = iss_s1_s;
  assign miq_if.issue_psrc2_vld = iss_s2v_s;
  assign miq_if.issue_psrc2     = iss_s2_s;
  assign miq_if.issue_pdst_vld  = iss_pdv_s;
  assign miq_if.issue_pdst      = iss_pd_s;
  assign miq_if.entry_cnt       = cnt_q;
  assign miq_if.empty           = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: tb/tb_idu_is_miq_queue.sv
// ---------------------------------------------------------------------------
// tb_idu_is_miq_queue
//   Directed scenarios with literal expectations, then randomized traffic.
//   A behavioural queue model (entries tagged with a creation sequence
//   number; oldest = smallest sequence) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_idu_is_miq_queue;
  localparam int DEPTH = 8, IID_W = 5, PREG_W = 6, OP_W = 17, NUM_WK = 10, CNT_W = 4;

  logic clk = 1'b0;
  logic rst_clk = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  idu_is_miq_queue_if #(.IID_W(IID_W), .PREG_W(PREG_W), .OP_W(OP_W),
                        .NUM_WK(NUM_WK), .CNT_W(CNT_W)) miq_if ();

  idu_is_miq_queue #(.DEPTH(DEPTH), .IID_W(IID_W), .PREG_W(PREG_W), .OP_W(OP_W),
                     .NUM_WK(NUM_WK), .CNT_W(CNT_W))
    dut (.clk(clk), .rst_clk(rst_clk), .miq_if(miq_if));

  initial forever #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          vld;
    longint      seq;
    logic [4:0]  iid;
    logic [16:0] op;
    bit          s1v, s1r, s2v, s2r, pdv;
    logic [5:0]  s1, s2, pd;
  } ent_t;

  ent_t   m [DEPTH];
  longint m_seq = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit m_hit(logic [5:0] p);
    for (int k = 0; k < NUM_WK; k++)
      if (miq_if.wk_vld[k] === 1'b1 && miq_if.wk_preg[k*PREG_W +: PREG_W] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_best();
    int b = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m[i].vld && m[i].s1r && m[i].s2r && (b < 0 || m[i].seq < m[b].seq)) b = i;
    return b;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].vld) c++;
    return c;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) m[i] = '{default: 0};
  endfunction

  function automatic void m_step();
    int b, c, fr;
    bit ifire, cfire;
    ent_t e;
    b  = m_best();
    c  = m_cnt();
    fr = -1;
    for (int i = 0; i < DEPTH; i++) if (!m[i].vld && fr < 0) fr = i;
    ifire = (b >= 0) && !miq_if.rtu_global_flush && miq_if.issue_rdy;
    cfire = miq_if.create_vld && (c != DEPTH) && !miq_if.rtu_global_flush;
    if (miq_if.rtu_global_flush) begin
      m_clear();
    end else begin
      for (int i = 0; i < DEPTH; i++) if (m[i].vld) begin
        m[i].s1r = m[i].s1r | m_hit(m[i].s1);
        m[i].s2r = m[i].s2r | m_hit(m[i].s2);
      end
      if (ifire) m[b] = '{default: 0};
      if (cfire) begin
        e.vld = 1'b1;
        e.seq = m_seq++;
        e.iid = miq_if.create_iid;
        e.op  = miq_if.create_op;
        e.s1v = miq_if.create_psrc1_vld;
        e.s1  = miq_if.create_psrc1;
        e.s1r = miq_if.create_psrc1_ready || !miq_if.create_psrc1_vld || m_hit(miq_if.create_psrc1);
        e.s2v = miq_if.create_psrc2_vld;
        e.s2  = miq_if.create_psrc2;
        e.s2r = miq_if.create_psrc2_ready || !miq_if.create_psrc2_vld || m_hit(miq_if.create_psrc2);
        e.pdv = miq_if.create_pdst_vld;
        e.pd  = miq_if.create_pdst_vld ? miq_if.create_pdst : 6'd0;
        m[fr] = e;
      end
    end
  endfunction

  // Model state advances on the same events as the design
  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge rst_clk);
      if (!rst_clk) m_clear();
      else m_step();
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    int b, c;
    @(negedge clk);
    if (rst_clk === 1'b1) begin
      b = m_best();
      c = m_cnt();
      chk("entry_cnt", miq_if.entry_cnt, c);
      chk("empty", miq_if.empty, c == 0);
      chk("create_rdy", miq_if.create_rdy, c != DEPTH);
      chk("issue_vld", miq_if.issue_vld, (b >= 0) && !miq_if.rtu_global_flush);
      if (b >= 0) begin
        chk("issue_iid", miq_if.issue_iid, m[b].iid);
        chk("issue_op", miq_if.issue_op, m[b].op);
        chk("issue_psrc1", {miq_if.issue_psrc1_vld, miq_if.issue_psrc1}, {m[b].s1v, m[b].s1});
        chk("issue_psrc2", {miq_if.issue_psrc2_vld, miq_if.issue_psrc2}, {m[b].s2v, m[b].s2});
        chk("issue_pdst", {miq_if.issue_pdst_vld, miq_if.issue_pdst}, {m[b].pdv, m[b].pd});
      end else begin
        chk("issue_fields_zero", {miq_if.issue_iid, miq_if.issue_op, miq_if.issue_psrc1_vld,
            miq_if.issue_psrc2_vld, miq_if.issue_pdst_vld}, 32'd0);
        chk("issue_pregs_zero", {miq_if.issue_psrc1, miq_if.issue_psrc2, miq_if.issue_pdst}, 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drv_create(input logic [4:0] iid, input bit s1v, input bit s1r, input logic [5:0] s1,
                            input bit s2v, input bit s2r, input logic [5:0] s2);
    miq_if.create_vld         = 1'b1;
    miq_if.create_iid         = iid;
    miq_if.create_op          = {iid, 12'hA53};
    miq_if.create_psrc1_vld   = s1v;
    miq_if.create_psrc1_ready = s1r;
    miq_if.create_psrc1       = s1;
    miq_if.create_psrc2_vld   = s2v;
    miq_if.create_psrc2_ready = s2r;
    miq_if.create_psrc2       = s2;
    miq_if.create_pdst_vld    = 1'b1;
    miq_if.create_pdst        = {1'b0, iid};
  endtask

  task automatic idle();
    miq_if.create_vld = 1'b0;
    miq_if.wk_vld     = '0;
    miq_if.wk_preg    = '0;
  endtask

  task automatic wake(input int bus, input logic [5:0] p);
    miq_if.wk_vld = '0;
    miq_if.wk_preg = '0;
    miq_if.wk_vld[bus] = 1'b1;
    miq_if.wk_preg[bus*PREG_W +: PREG_W] = p;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NUM_WK*PREG_W-1:0] wp;
    miq_if.rtu_global_flush = 1'b0;
    miq_if.issue_rdy = 1'b0;
    drv_create(5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    idle();
    repeat (3) tick();
    look();
    chk("rst_cnt", miq_if.entry_cnt, 4'd0);
    chk("rst_empty", miq_if.empty, 1'b1);
    chk("rst_create_rdy", miq_if.create_rdy, 1'b1);
    chk("rst_issue_vld", miq_if.issue_vld, 1'b0);
    chk("rst_issue_iid", miq_if.issue_iid, 5'd0);
    tick();
    rst_clk = 1'b1;

    // 1: ready create issues the next cycle
    drv_create(5'd3, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 6'd2);
    miq_if.issue_rdy = 1'b1;
    tick(); idle(); look();
    chk("t1_vld", miq_if.issue_vld, 1'b1);
    chk("t1_iid", miq_if.issue_iid, 5'd3);
    chk("t1_cnt", miq_if.entry_cnt, 4'd1);
    tick(); look();
    chk("t1_cnt_after", miq_if.entry_cnt, 4'd0);
    chk("t1_empty", miq_if.empty, 1'b1);

    // 2: pending src woken two cycles later, issued the cycle after
    drv_create(5'd7, 1'b1, 1'b0, 6'd12, 1'b0, 1'b0, 6'd0);
    tick(); idle(); look();
    chk("t2_wait0", miq_if.issue_vld, 1'b0);
    tick(); wake(4, 6'd12); look();
    chk("t2_wait1", miq_if.issue_vld, 1'b0);
    tick(); idle(); look();
    chk("t2_vld", miq_if.issue_vld, 1'b1);
    chk("t2_iid", miq_if.issue_iid, 5'd7);
    tick();

    // 3: oldest-ready order 2,1,3
    miq_if.issue_rdy = 1'b0;
    drv_create(5'd1, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 6'd0);
    tick(); drv_create(5'd2, 1'b1, 1'b1, 6'd9, 1'b1, 1'b1, 6'd10);
    tick(); drv_create(5'd3, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd11);
    tick(); idle(); miq_if.issue_rdy = 1'b1; wake(2, 6'd5); look();
    chk("t3_first", miq_if.issue_iid, 5'd2);
    tick(); idle(); look();
    chk("t3_second", miq_if.issue_iid, 5'd1);
    chk("t3_second_psrc1", miq_if.issue_psrc1, 6'd5);
    tick(); look();
    chk("t3_third", miq_if.issue_iid, 5'd3);
    chk("t3_third_pdst", miq_if.issue_pdst, 6'd3);
    tick(); look();
    chk("t3_drained", miq_if.issue_vld, 1'b0);

    // 4: wakeup in the create cycle counts
    drv_create(5'd4, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd7);
    wake(0, 6'd7);
    tick(); idle(); look();
    chk("t4_vld", miq_if.issue_vld, 1'b1);
    chk("t4_iid", miq_if.issue_iid, 5'd4);
    tick();

    // 5: full queue back-pressure
    miq_if.issue_rdy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drv_create(5'(8 + k), 1'b1, 1'b1, 6'(k), 1'b0, 1'b0, 6'd0);
      tick();
    end
    idle(); look();
    chk("t5_full_cnt", miq_if.entry_cnt, 4'd8);
    chk("t5_full_rdy", miq_if.create_rdy, 1'b0);
    drv_create(5'd30, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 6'd2);
    tick(); miq_if.issue_rdy = 1'b1; look();
    chk("t5_ninth_ignored", miq_if.entry_cnt, 4'd8);
    chk("t5_oldest", miq_if.issue_iid, 5'd8);
    tick(); idle(); look();
    chk("t5_cnt7", miq_if.entry_cnt, 4'd7);
    chk("t5_rdy_back", miq_if.create_rdy, 1'b1);
    chk("t5_next", miq_if.issue_iid, 5'd9);
    for (int k = 2; k < DEPTH; k++) begin
      tick(); look();
      chk("t5_drain", miq_if.issue_iid, 5'(8 + k));
    end
    tick(); look();
    chk("t5_empty", miq_if.empty, 1'b1);

    // 6: flush with resident entries and a same-cycle create
    miq_if.issue_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drv_create(5'(16 + k), 1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 6'd0);
      tick();
    end
    drv_create(5'd21, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    miq_if.rtu_global_flush = 1'b1;
    miq_if.issue_rdy = 1'b1;
    look();
    chk("t6_flush_gate", miq_if.issue_vld, 1'b0);
    chk("t6_cnt5", miq_if.entry_cnt, 4'd5);
    tick(); miq_if.rtu_global_flush = 1'b0; idle(); miq_if.issue_rdy = 1'b0; look();
    chk("t6_cnt0", miq_if.entry_cnt, 4'd0);
    chk("t6_empty", miq_if.empty, 1'b1);
    chk("t6_vld", miq_if.issue_vld, 1'b0);

    // 7: asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) begin
      drv_create(5'(22 + k), 1'b1, 1'b1, 6'd4, 1'b0, 1'b0, 6'd0);
      tick();
    end
    idle(); look();
    chk("t7_cnt3", miq_if.entry_cnt, 4'd3);
    #2 rst_clk = 1'b0;
    #1;
    chk("t7_async_cnt", miq_if.entry_cnt, 4'd0);
    chk("t7_async_empty", miq_if.empty, 1'b1);
    chk("t7_async_vld", miq_if.issue_vld, 1'b0);
    tick(); tick();
    rst_clk = 1'b1;

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      miq_if.create_vld         = ($urandom_range(0, 99) < 60);
      miq_if.create_iid         = 5'($urandom);
      miq_if.create_op          = 17'($urandom);
      miq_if.create_psrc1_vld   = 1'($urandom);
      miq_if.create_psrc1_ready = ($urandom_range(0, 99) < 40);
      miq_if.create_psrc1       = 6'($urandom_range(0, 15));
      miq_if.create_psrc2_vld   = 1'($urandom);
      miq_if.create_psrc2_ready = ($urandom_range(0, 99) < 40);
      miq_if.create_psrc2       = 6'($urandom_range(0, 15));
      miq_if.create_pdst_vld    = 1'($urandom);
      miq_if.create_pdst        = 6'($urandom);
      for (int k = 0; k < NUM_WK; k++) begin
        miq_if.wk_vld[k] = ($urandom_range(0, 99) < 12);
        wp[k*PREG_W +: PREG_W] = 6'($urandom_range(0, 15));
      end
      miq_if.wk_preg          = wp;
      miq_if.issue_rdy        = ($urandom_range(0, 99) < 70);
      miq_if.rtu_global_flush = ($urandom_range(0, 199) < 3);
      tick();
    end
    idle();
    miq_if.rtu_global_flush = 1'b0;
    miq_if.issue_rdy = 1'b1;
    repeat (20) tick();
    look();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
